// File: rtl/accum_pkg.sv
// accum_pkg: shared opcode/state encodings and defaults for the accumulator responder
package accum_pkg;
    localparam int WIDTH_DEF = 32;
    typedef enum logic [1:0] {OP_NONE = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10, OP_RSVD = 2'b11} op_t;
    typedef enum logic [1:0] {IDLE = 2'b00, RESP = 2'b01, RELEASE = 2'b10} state_t;
endpackage

// File: rtl/accum_mem_responder_if.sv
// accum_mem_responder_if: operand bus between the granted processor and the responder
interface accum_mem_responder_if
    import accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    op_t              op;
    logic [WIDTH-1:0] wr_data;
    logic             ack;
    logic             nack;
    logic [WIDTH-1:0] rd_data;
    modport master (output op, wr_data, input ack, nack, rd_data);
    modport slave  (input op, wr_data, output ack, nack, rd_data);
endinterface

// File: rtl/accum_lifo.sv
// accum_lifo: operand stack storage; count doubles as the pointer and the full/empty discriminator
module accum_lifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] bottom,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    localparam int AW = CW - 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    sp;
    logic             do_push, do_pop;
    assign sp      = count[AW-1:0];
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;
    assign dout    = mem[sp - 1'b1];
    assign bottom  = mem[0];
    // occupancy tracks accepted pushes and pops; push wins if both are ever asserted
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else count <= do_push ? count + 1'b1 : do_pop ? count - 1'b1 : count;
    // storage is never reset; only slots below count are meaningful
    always_ff @(posedge clk)
        if (do_push) mem[sp] <= din;
endmodule

// File: rtl/accum_mem_responder.sv
// accum_mem_responder: bus target serving pops/pushes on the operand stack and flagging the final sum
module accum_mem_responder
    import accum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    accum_mem_responder_if.slave  bus,
    input  logic                  load_valid,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  load_last,
    output logic [CW-1:0]         count,
    output logic [WIDTH-1:0]      result,
    output logic                  result_valid,
    output logic                  overflow
);
    state_t           state, next;
    logic [CW-1:0]    inflight;
    logic             load_done;
    logic             is_rd, is_wr, serve, do_pop, do_push, full, empty;
    logic [WIDTH-1:0] top, bottom;
    assign is_rd   = bus.op == OP_READ;
    assign is_wr   = bus.op == OP_WRITE;
    assign serve   = state == IDLE && !load_valid && (is_rd || is_wr);
    assign do_pop  = serve && is_rd && !empty;
    assign do_push = serve && is_wr && !full;
    accum_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_lifo (
        .clk    (clk),
        .reset  (reset),
        .push   ((load_valid && !full) || do_push),
        .pop    (do_pop),
        .din    (load_valid ? load_data : bus.wr_data),
        .dout   (top),
        .bottom (bottom),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );
    // a held opcode parks the FSM in RELEASE so it is serviced only once
    always_comb begin
        next = state;
        next = state == IDLE ? (serve ? RESP : IDLE) : state == RESP ? RELEASE : (is_rd || is_wr) ? RELEASE : IDLE;
    end
    // state register plus the registered handshake, in-flight and sticky flags
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            bus.ack     <= 1'b0;
            bus.nack    <= 1'b0;
            bus.rd_data <= '0;
            inflight    <= '0;
            overflow    <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            state       <= next;
            bus.ack     <= do_pop || do_push;
            bus.nack    <= serve && !(do_pop || do_push);
            bus.rd_data <= do_pop ? top : (serve && is_rd) ? '0 : bus.rd_data;
            inflight    <= do_pop ? inflight + 1'b1 : do_push ? (inflight >= CW'(2) ? inflight - CW'(2) : '0) : inflight;
            overflow    <= overflow || (load_valid && full) || (serve && is_wr && full);
            load_done   <= load_done || (load_valid && load_last);
        end
    assign result_valid = load_done && count == CW'(1) && inflight == '0 && state == IDLE;
    assign result       = result_valid ? bottom : '0;
endmodule

// File: tb/tb_accum_mem_responder.sv
// tb_accum_mem_responder: directed and randomized checks against a transaction-level stack model
module tb_accum_mem_responder;
    import accum_pkg::*;
    localparam int W = 32;
    localparam int D = 16;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_last = 1'b0;
    logic [4:0]   count;
    logic [W-1:0] result;
    logic         result_valid, overflow;
    accum_mem_responder_if #(.WIDTH(W)) bus ();
    accum_mem_responder #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .count        (count),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow)
    );
    always #5 clk = ~clk;
    int           n_tests = 0, n_fail = 0;
    logic [W-1:0] stk [$];
    int           inflight_m = 0;
    bit           ovf_m = 0, done_m = 0;
    logic [W-1:0] rd_m = '0;

    task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_status(string tag);
        bit rv;
        rv = done_m && stk.size() == 1 && inflight_m == 0;
        check({tag, ".count"}, W'(count), W'(stk.size()));
        check({tag, ".ovf"}, W'(overflow), W'(ovf_m));
        check({tag, ".rv"}, W'(result_valid), W'(rv));
        check({tag, ".result"}, result, rv ? stk[0] : '0);
    endtask

    task automatic do_reset();
        bus.op = OP_NONE;
        load_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        stk.delete();
        inflight_m = 0;
        ovf_m = 0;
        done_m = 0;
        rd_m = '0;
    endtask

    task automatic do_load(logic [W-1:0] v, bit last);
        load_valid = 1'b1;
        load_data = v;
        load_last = last;
        @(posedge clk);
        #1 load_valid = 1'b0;
        load_last = 1'b0;
        if (stk.size() < D) stk.push_back(v);
        else ovf_m = 1;
        if (last) done_m = 1;
        check("load.count", W'(count), W'(stk.size()));
    endtask

    task automatic do_op(op_t o, logic [W-1:0] d, string tag);
        bit ea, en;
        ea = 0;
        en = 0;
        if (o == OP_READ) begin
            if (stk.size() > 0) begin
                ea = 1;
                rd_m = stk.pop_back();
                inflight_m++;
            end else begin
                en = 1;
                rd_m = '0;
            end
        end else if (o == OP_WRITE) begin
            if (stk.size() < D) begin
                ea = 1;
                stk.push_back(d);
                inflight_m = inflight_m >= 2 ? inflight_m - 2 : 0;
            end else begin
                en = 1;
                ovf_m = 1;
            end
        end
        bus.op = o;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        check({tag, ".ack"}, W'(bus.ack), W'(ea));
        check({tag, ".nack"}, W'(bus.nack), W'(en));
        check({tag, ".rd"}, bus.rd_data, rd_m);
        bus.op = OP_NONE;
        @(posedge clk);
        #1 check({tag, ".pulse"}, W'({bus.ack, bus.nack}), '0);
        @(posedge clk);
        #1 check_status(tag);
    endtask

    initial begin
        int acks;
        bus.op = OP_NONE;
        bus.wr_data = '0;
        reset = 1'b1;
        #12;
        check("rst.ack", W'(bus.ack), '0);
        check("rst.nack", W'(bus.nack), '0);
        check("rst.rd", bus.rd_data, '0);
        check_status("rst");
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 4; i++) do_load(W'(i), i == 4);
        check_status("pre");
        do_op(OP_READ, '0, "rd4");
        check("rd4.inflight", W'(dut.inflight), 1);
        for (int r = 0; r < 3; r++) begin
            logic [W-1:0] a, b;
            a = stk[stk.size()-1];
            b = stk[stk.size()-2];
            if (r > 0) do_op(OP_READ, '0, "sum.rda");
            do_op(OP_READ, '0, "sum.rdb");
            if (r == 0) b = a;
            do_op(OP_WRITE, r == 0 ? 32'd7 : a + b, "sum.wr");
        end
        check("sum.rv", W'(result_valid), 1);
        check("sum.result", result, 10);
        do_op(OP_READ, '0, "last");
        do_op(OP_READ, '0, "empty");
        for (int i = 0; i < D; i++) do_load(W'(100 + i), 0);
        do_op(OP_WRITE, 32'h55, "full");
        do_op(OP_READ, '0, "sticky");
        check("sticky.ovf", W'(overflow), 1);
        do_reset();
        for (int i = 0; i < 3; i++) do_load(W'(20 + i), i == 2);
        bus.op = OP_READ;
        acks = 0;
        repeat (5) begin
            @(posedge clk);
            #1 acks += int'(bus.ack);
        end
        check("hold.acks", W'(acks), 1);
        check("hold.rd", bus.rd_data, 22);
        check("hold.count", W'(count), 2);
        void'(stk.pop_back());
        inflight_m++;
        rd_m = 32'd22;
        bus.op = OP_NONE;
        repeat (2) @(posedge clk);
        #1 check_status("hold");
        bus.op = OP_READ;
        @(posedge clk);
        #1 check("rr.ack", W'(bus.ack), 1);
        reset = 1'b1;
        #1;
        check("rr.ack0", W'(bus.ack), 0);
        check("rr.count", W'(count), 0);
        check("rr.rv", W'(result_valid), 0);
        do_reset();
        do_load(32'd9, 1);
        check_status("nine");
        check("nine.result", result, 9);
        for (int round = 0; round < 3; round++) begin
            int n;
            do_reset();
            n = $urandom_range(1, D);
            for (int i = 0; i < n; i++) do_load($urandom, i == n - 1);
            for (int k = 0; k < 40; k++) begin
                int r;
                r = $urandom_range(0, 9);
                do_op(r < 5 ? OP_READ : r < 9 ? OP_WRITE : OP_RSVD, $urandom, "rand");
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
